// File: rtl/icache_axi_burst_reader.sv
// I-cache line-fill engine: one request becomes one AXI4 INCR read burst, streamed back beat by beat.
// Optional rresp/rlast checking on bus_err is built when ICACHE_AXI_RESP_CHECK_EN is defined.
module icache_axi_burst_reader #(
  parameter int          BURST_LEN = 16,
  parameter int          LINE_LSB  = 6,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read_req,
  input  logic [31:0] inst_addr_mmu,
  output logic        inst_addr_ok,
  output logic [31:0] inst_read_data,
  output logic        mmu_valid,
  output logic        mmu_last,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             beat;
  logic             final_beat;

  // Handshakes: a transfer happens on any rising edge where valid && ready are both high;
  // arvalid/araddr stay stable until arready, and every rvalid beat in DATA is taken (rready=1).
  assign beat           = rready & rvalid;
  assign final_beat     = beat & (beat_cnt == LAST_BEAT);
  assign mmu_valid      = beat;
  assign mmu_last       = final_beat;
  assign inst_read_data = rdata;

  assign arid    = AXI_ID;
  assign arlen   = 8'(BURST_LEN - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  always_comb begin
    state_nxt    = state;
    inst_addr_ok = 1'b0;
    rready       = 1'b0;
    case (state)
      IDLE: begin
        inst_addr_ok = inst_read_req;
        if (inst_read_req) state_nxt = ADDR;
      end
      ADDR: begin
        if (arready) state_nxt = DATA;
      end
      DATA: begin
        rready = 1'b1;
        if (final_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      arvalid  <= 1'b0;
      araddr   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (inst_read_req) begin
            araddr   <= {inst_addr_mmu[31:LINE_LSB], {LINE_LSB{1'b0}}};
            arvalid  <= 1'b1;
            beat_cnt <= '0;
          end
        end
        ADDR: begin
          if (arready) arvalid <= 1'b0;
        end
        DATA: begin
          // Wraps to zero on the final beat, so the next burst starts clean either way.
          if (beat) beat_cnt <= beat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ICACHE_AXI_RESP_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (beat && ((rresp != 2'b00) || (rlast != (beat_cnt == LAST_BEAT)))) begin
      bus_err <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast};
  assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_icache_axi_burst_reader.sv
// Randomized bench for icache_axi_burst_reader: AXI slave model, request driver and a
// scoreboard monitor that follows the request -> address -> 16-beat life of each line fill.
module tb_icache_axi_burst_reader;

  localparam int BURST_LEN = 16;

  logic        clk = 1'b0;
  logic        rst_drv, rst_slv, rst;
  logic        inst_read_req;
  logic [31:0] inst_addr_mmu;
  logic        inst_addr_ok;
  logic [31:0] inst_read_data;
  logic        mmu_valid, mmu_last;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, bus_err;

  assign rst = rst_drv | rst_slv;

  icache_axi_burst_reader dut (
    .clk(clk), .rst(rst),
    .inst_read_req(inst_read_req), .inst_addr_mmu(inst_addr_mmu), .inst_addr_ok(inst_addr_ok),
    .inst_read_data(inst_read_data), .mmu_valid(mmu_valid), .mmu_last(mmu_last),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bus_err(bus_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];       // {last, data} per beat, pushed by the slave model
  logic [31:0] exp_addr_q[$];  // line address per accepted request
  bit checking = 0;
  int phase = 0;               // 0 idle, 1 address outstanding, 2 data streaming
  int beat_m = 0;
  bit err_m = 0;
  int acc_cnt = 0;

  // slave controls
  int ar_mode = 0, r_mode = 0, d_mode = 0;
  bit reset_mode = 0, inject_err = 0;
  int beats_left = 0, sbeat = 0, ar_wait = 0;
  bit r_tog = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // AXI slave model
  initial begin
    bit arf, rf, go;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rst_slv = 0;
    forever begin
      @(negedge clk);
      arf = arvalid && arready;
      rf  = rvalid && rready;
      @(posedge clk); #2;
      if (rst) begin
        beats_left = 0; sbeat = 0; ar_wait = 0;
        rvalid = 0; arready = 0; rlast = 0; rresp = 0; rst_slv = 0;
        continue;
      end
      if (arf) begin beats_left = BURST_LEN; sbeat = 0; end
      if (rf) begin beats_left--; sbeat++; end
      if (beats_left != 0) arready = 0;
      else begin
        case (ar_mode)
          1: arready = 1;
          2: begin
            if (arvalid) begin arready = (ar_wait >= 5); ar_wait++; end
            else begin arready = 0; ar_wait = 0; end
          end
          default: arready = 1'($urandom_range(0, 1));
        endcase
      end
      go = 0;
      if (beats_left > 0) begin
        case (r_mode)
          1: go = 1;
          2: begin go = r_tog; r_tog = !r_tog; end
          default: go = ($urandom_range(0, 9) < 7);
        endcase
      end
      rvalid = go;
      if (go) begin
        rdata = d_mode ? 32'hA0 + 32'(sbeat) : $urandom;
        rresp = (inject_err && sbeat == 2) ? 2'b10 : 2'b00;
        rlast = (sbeat == BURST_LEN - 1) || (inject_err && sbeat == 8);
        exp_q.push_back({(sbeat == BURST_LEN - 1), rdata});
        if (reset_mode && sbeat == 6) begin rst_slv = 1; reset_mode = 0; end
      end else begin
        rresp = 0; rlast = 0; rdata = $urandom;
      end
    end
  end

  // monitor: compares DUT outputs against the reference life-cycle of each line fill
  initial begin
    logic [32:0] e;
    logic [31:0] ea;
    bit fire;
    forever begin
      @(negedge clk);
      fire = (phase == 2) && rvalid;
      if (checking) begin
        chk("inst_addr_ok", inst_addr_ok, inst_read_req && phase == 0);
        chk("arvalid", arvalid, phase == 1);
        chk("rready", rready, phase == 2);
        chk("bus_err", bus_err, err_m);
        if (phase == 1) begin
          ea = (exp_addr_q.size() != 0) ? exp_addr_q[0] : 32'hDEAD_BEEF;
          chk("araddr", araddr, ea);
          chk("arlen", arlen, BURST_LEN - 1);
          chk("arsize_arburst_arid", {arsize, arburst, arid}, {3'b010, 2'b01, 4'd0});
        end
        chk("mmu_valid", mmu_valid, fire);
        if (mmu_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected: got data 0x%0h expected no beat at %0t", inst_read_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("inst_read_data", inst_read_data, e[31:0]);
            chk("mmu_last", mmu_last, e[32]);
          end
        end else begin
          chk("mmu_last_unqualified", mmu_last, 0);
        end
      end
      if (phase == 0 && inst_read_req) begin
        exp_addr_q.push_back(inst_addr_mmu & 32'hFFFF_FFC0);
        acc_cnt++;
        phase = 1;
      end else if (phase == 1 && arready) begin
        void'(exp_addr_q.pop_front());
        phase = 2; beat_m = 0;
      end else if (fire) begin
`ifdef ICACHE_AXI_RESP_CHECK_EN
        if (rresp != 2'b00 || rlast != (beat_m == BURST_LEN - 1)) err_m = 1;
`endif
        beat_m++;
        if (beat_m == BURST_LEN) phase = 0;
      end
      if (rst) begin
        phase = 0; beat_m = 0; err_m = 0;
        exp_addr_q.delete();
        exp_q.delete();
      end
    end
  end

  // driver tasks
  task automatic request(input logic [31:0] a);
    int start;
    bit got;
    @(posedge clk); #1;
    inst_addr_mmu = a; inst_read_req = 1;
    start = acc_cnt; got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk); #1;
      if (acc_cnt != start) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL request_accept: no accept within 400 cycles for addr 0x%0h", a);
    end
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    inst_read_req = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk); #1;
      if (phase == 0 && beats_left == 0 && exp_q.size() == 0 && exp_addr_q.size() == 0) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_idle: burst did not complete within 2000 cycles, phase %0d left %0d", phase, beats_left);
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst_drv = 1;
    @(posedge clk); #1; rst_drv = 0;
  endtask

  // stimulus
  initial begin
    rst_drv = 1; inst_read_req = 0; inst_addr_mmu = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_araddr", araddr, 0);
    chk("reset_rready", rready, 0);
    chk("reset_mmu_valid", {mmu_valid, mmu_last}, 0);
    chk("reset_inst_addr_ok", inst_addr_ok, 0);
    chk("reset_bus_err", bus_err, 0);
    @(posedge clk); #1; rst_drv = 0;
    checking = 1;

    // incrementing data, immediate arready, no gaps
    ar_mode = 1; r_mode = 1; d_mode = 1;
    request(32'h1234_5678); drop_req(); wait_idle();

    // delayed arready, toggling rvalid
    ar_mode = 2; r_mode = 2; d_mode = 0;
    request(32'h8000_0FFC); drop_req(); wait_idle();

    // request held through DATA with a new address
    ar_mode = 0; r_mode = 0;
    request(32'h1234_5678); request(32'h0000_2040); drop_req(); wait_idle();

    // reset on beat 7, then a clean burst
    r_mode = 1; reset_mode = 1;
    request($urandom); drop_req(); wait_idle();
    r_mode = 0;
    request($urandom); drop_req(); wait_idle();

    // bad rresp on beat 3 and early rlast on beat 9
    inject_err = 1; r_mode = 1; d_mode = 1;
    request(32'h0000_4000); drop_req(); wait_idle();
    inject_err = 0; d_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef ICACHE_AXI_RESP_CHECK_EN
    chk("bus_err_sticky", bus_err, 1);
`else
    chk("bus_err_disabled", bus_err, 0);
`endif
    pulse_rst();
    @(negedge clk);
    chk("bus_err_after_rst", bus_err, 0);

    // randomized bursts, some with a request pulse dropped while busy
    for (int n = 0; n < 14; n++) begin
      ar_mode = $urandom_range(0, 2);
      r_mode = $urandom_range(0, 2);
      request($urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1; inst_addr_mmu = $urandom;
      end
      drop_req();
      wait_idle();
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
